// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory path: size encodings, the
// load/store FSM state type and address-alignment helpers.
package mips_mem_pkg;

    localparam int MEM_INDEX_BITS_DEF = 7;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_FIN  = 3'd4
    } lsu_state_t;

    // Encoding 11 is handled exactly like a word access.
    function automatic logic is_word_size(input logic [1:0] sz);
        return sz[1];
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        logic bad;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            default: bad = |lo;
        endcase
        return bad;
    endfunction

    function automatic logic [1:0] align_lo(input logic [1:0] sz, input logic [1:0] lo);
        logic [1:0] al;
        case (sz)
            SZ_BYTE: al = lo;
            SZ_HALF: al = {lo[1], 1'b0};
            default: al = 2'b00;
        endcase
        return al;
    endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Combinational lane logic: extracts and extends a load lane from a memory
// word, and merges right-aligned store data into the selected lane.
module lsu_lane_merge
    import mips_mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned_ld,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_st_data
);

    logic [4:0]  w_shamt;
    logic [31:0] w_lane_mask;
    logic [31:0] w_lane_src;
    logic [31:0] w_shifted;

    // Lane position, load extraction and store merge.
    always_comb begin
        w_shamt     = 5'd0;
        w_lane_mask = 32'hFFFF_FFFF;
        w_lane_src  = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                w_shamt     = {i_addr_lo, 3'b000};
                w_lane_mask = 32'h0000_00FF << w_shamt;
                w_lane_src  = {24'h00_0000, i_wdata[7:0]} << w_shamt;
            end
            SZ_HALF: begin
                w_shamt     = {i_addr_lo[1], 4'b0000};
                w_lane_mask = 32'h0000_FFFF << w_shamt;
                w_lane_src  = {16'h0000, i_wdata[15:0]} << w_shamt;
            end
            default: begin
                w_shamt     = 5'd0;
                w_lane_mask = 32'hFFFF_FFFF;
                w_lane_src  = i_wdata;
            end
        endcase

        w_shifted = i_word >> w_shamt;
        o_st_data = (i_word & ~w_lane_mask) | (w_lane_src & w_lane_mask);

        case (i_size)
            SZ_BYTE: begin
                if (i_unsigned_ld) begin
                    o_ld_data = {24'h00_0000, w_shifted[7:0]};
                end else begin
                    o_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
                end
            end
            SZ_HALF: begin
                if (i_unsigned_ld) begin
                    o_ld_data = {16'h0000, w_shifted[15:0]};
                end else begin
                    o_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
                end
            end
            default: o_ld_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, sub-word stores done as
// read-modify-write. Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int MEM_INDEX_BITS = MEM_INDEX_BITS_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic [31:0] mem_adress,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_data
);

    lsu_state_t  r_state;
    lsu_state_t  w_next_state;

    logic        w_reject;
    logic        w_accept;
    logic [1:0]  w_addr_lo;
    logic        w_unused_addr;

    logic [1:0]  r_size;
    logic [1:0]  r_addr_lo;
    logic        r_is_store;
    logic        r_unsigned_ld;
    logic [31:0] r_wdata;

    logic        r_busy;
    logic        r_done;
    logic        r_misalign;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [31:0] r_rdata;
    logic [31:0] r_mem_adress;
    logic [31:0] r_mem_write_data;

    logic [31:0] w_ld_data;
    logic [31:0] w_st_data;

    // Address bits above the memory index are not decoded.
    assign w_unused_addr = ^addr[31:MEM_INDEX_BITS+2];

    // Request qualification and low address bits used for lane selection.
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        w_reject  = (r_state == ST_IDLE) && req && is_misaligned(size, addr[1:0]);
        w_addr_lo = addr[1:0];
`else
        w_reject  = 1'b0;
        w_addr_lo = align_lo(size, addr[1:0]);
`endif
        w_accept  = (r_state == ST_IDLE) && req && !w_reject;
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (is_store && is_word_size(size)) ? ST_WR : ST_RD;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RD:   w_next_state = ST_CAP;
            ST_CAP:  w_next_state = r_is_store ? ST_WR : ST_FIN;
            ST_WR:   w_next_state = ST_FIN;
            ST_FIN:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Strobes are decoded from the next state so they are registered yet aligned to the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_misalign  <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_busy      <= (w_next_state != ST_IDLE);
            r_done      <= (w_next_state == ST_FIN);
            r_misalign  <= w_reject;
            r_mem_read  <= (w_next_state == ST_RD);
            r_mem_write <= (w_next_state == ST_WR);
        end
    end

    // Request latch, load result and write-data formation.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_size           <= 2'b00;
            r_addr_lo        <= 2'b00;
            r_is_store       <= 1'b0;
            r_unsigned_ld    <= 1'b0;
            r_wdata          <= 32'h0000_0000;
            r_rdata          <= 32'h0000_0000;
            r_mem_adress     <= 32'h0000_0000;
            r_mem_write_data <= 32'h0000_0000;
        end else if (w_accept) begin
            r_size        <= size;
            r_addr_lo     <= w_addr_lo;
            r_is_store    <= is_store;
            r_unsigned_ld <= unsigned_ld;
            r_wdata       <= wdata;
            r_mem_adress  <= {{(32-MEM_INDEX_BITS){1'b0}}, addr[MEM_INDEX_BITS+1:2]};
            if (is_store && is_word_size(size)) begin
                r_mem_write_data <= wdata;
            end else begin
                r_mem_write_data <= r_mem_write_data;
            end
        end else if (r_state == ST_CAP) begin
            if (r_is_store) begin
                r_mem_write_data <= w_st_data;
            end else begin
                r_rdata <= w_ld_data;
            end
        end else begin
            r_rdata <= r_rdata;
        end
    end

    lsu_lane_merge u_lane_merge (
        .i_size        (r_size),
        .i_addr_lo     (r_addr_lo),
        .i_unsigned_ld (r_unsigned_ld),
        .i_word        (mem_data),
        .i_wdata       (r_wdata),
        .o_ld_data     (w_ld_data),
        .o_st_data     (w_st_data)
    );

    assign busy           = r_busy;
    assign done           = r_done;
    assign misalign       = r_misalign;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign rdata          = r_rdata;
    assign mem_adress     = r_mem_adress;
    assign mem_write_data = r_mem_write_data;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory interface in the MIPS datapath. Accepts one load or store request at a time from the execute stage and drives `mem_read`/`mem_write`, the word address and the write data toward the data memory. Byte and halfword loads are extracted from the returned word and extended. Sub-word stores are done as read-modify-write, because the memory only writes whole words.

## Interface
Parameters:
- `MEM_INDEX_BITS`, 7: number of word-index bits the memory decodes; the upper bits of `mem_adress` are driven 0.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `req`  in  1: request strobe; sampled only in IDLE.
- `is_store`  in  1: 1 = store, 0 = load.
- `size`  in  2: 00 byte, 01 halfword, 10 word; 11 is treated as word.
- `unsigned_ld`  in  1: 1 = zero-extend sub-word loads, 0 = sign-extend.
- `addr`  in  32: byte address.
- `wdata`  in  32: store data, right-aligned.
- `busy`  out  1: high from the cycle after acceptance until `done`.
- `done`  out  1: one-cycle completion pulse.
- `rdata`  out  32: load result; held until the next load completes.
- `misalign`  out  1: one-cycle pulse when a request is rejected.
- `mem_adress`  out  32: word index, equal to `{0, addr[MEM_INDEX_BITS+1:2]}`.
- `mem_write_data`  out  32: full word to write.
- `mem_write`  out  1: write strobe to the memory.
- `mem_read`  out  1: read strobe to the memory.
- `mem_data`  in  32: memory read register; valid the cycle after the `mem_read` edge.

## Operation
- FSM states: IDLE, RD, CAP, WR, FIN.
- IDLE → RD: when `req` is high and the request is a load or a sub-word store.
- IDLE → WR: when `req` is high and the request is a word store.
- RD → CAP: unconditional.
- CAP → FIN: for a load.
- CAP → WR: for a sub-word store.
- WR → FIN: unconditional.
- FIN → IDLE: unconditional; `done` is high while in FIN.
- On acceptance, `addr`, `wdata`, `size`, `is_store` and `unsigned_ld` are latched. Input changes after acceptance have no effect.
- `mem_read` is high only in RD. `mem_write` is high only in WR. The two are never high in the same cycle.
- Lane selection:
  - byte: `addr[1:0]` selects bits [8k+7:8k], where k is the value of `addr[1:0]`.
  - halfword: `addr[1]` selects the upper or lower 16 bits.
  - Little-endian.
- Load: in CAP, the selected lane of `mem_data` is extended to 32 bits and registered into `rdata`.
- Sub-word store: in CAP, the selected lane of the captured `mem_data` is replaced with the low bits of `wdata` to form `mem_write_data`. All other lanes are unchanged.
- Word store: `mem_write_data` = `wdata`.
- `req` while not in IDLE is ignored. No queueing.

## Timing
- Reset values: state IDLE. `busy`, `done`, `misalign`, `mem_read` and `mem_write` are all 0. `rdata`, `mem_adress` and `mem_write_data` are all 0.
- Reset asserted mid-operation: return to IDLE on that edge and drop all strobes. No `done` is issued. A memory write already strobed is not undone.
- Latency, counted from the accepting edge E:
  - load: `done` during cycle E+3, with `rdata` valid in the same cycle.
  - word store: `done` during cycle E+2.
  - sub-word store: `done` during cycle E+4.
- Back-to-back: a new `req` is accepted in IDLE the cycle after FIN, so the minimum issue interval is equal to the latency plus 1.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A halfword request with `addr[0]`=1 is rejected.
  - A word request with `addr[1:0]`≠0 is rejected.
  - A rejected request pulses `misalign` for one cycle at E+1, stays in IDLE, produces no memory strobe and no `done`.
- Undefined:
  - Offending low address bits are forced to 0; the access proceeds normally.
  - `misalign` is tied 0.

## Structure
- Shared package `mips_mem_pkg` contains:
  - size encodings: `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - the FSM state enum `lsu_state_t`;
  - the width constant `MEM_INDEX_BITS_DEF` = 7.
- Sub-module `lsu_lane_merge`: purely combinational. Performs load extract/extend and store merge from `(size, addr[1:0], unsigned_ld, word, wdata)`.

## Test plan
- Word store then word load: store `addr`=0x34, `wdata`=0xDEADBEEF, then load 0x34. Required: `mem_adress`=13 in WR; `rdata`=0xDEADBEEF, `done` at E+3.
- Signed byte load: memory word 13 = 0x80FF7F01, load byte at 0x37 with `unsigned_ld`=0. Required: `rdata`=0xFFFFFF80; the same access with `unsigned_ld`=1 gives 0x00000080.
- Sub-word store RMW: word 13 = 0x11223344, store halfword 0xABCD at 0x36. Required: `mem_read` at E+1, `mem_write` at E+3 with `mem_write_data`=0xABCD3344, `done` at E+4.
- Busy and reset: `req` held high during a load is ignored. Required: exactly one memory access. Then `reset` asserted in CAP. Required: next cycle IDLE, all strobes 0, no `done`.
- Misaligned word load at 0x35 with `LSU_MISALIGN_TRAP_EN` defined. Required: `misalign` pulse at E+1, no `mem_read`. Without the macro: a read of word 13 completes normally.
